// File: rtl/aes_key_expand_pkg.sv
// Shared types and constants for the AES-128 key schedule slice.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam logic [3:0]  LAST_IDX   = 4'(NUM_ROUNDS);

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OUT,
    ST_EXPAND
  } state_t;

  // Index 0 is unused; round r uses RCON[r].
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-in / round-key-out bus of aes_key_expand.
// Read-back signals exist only when AES_KEY_EXP_STORE_EN is defined.
interface aes_key_expand_if;
  import aes_pkg::*;

  logic       i_key_vld;
  key_t       i_key;
  logic       o_key_rdy;
  logic       o_rkey_vld;
  key_t       o_rkey;
  logic [3:0] o_rkey_idx;
  logic       i_rkey_rdy;
  logic       o_busy;

`ifdef AES_KEY_EXP_STORE_EN
  logic [3:0] i_rd_idx;
  key_t       o_rd_key;
  logic       o_store_done;

  modport slave (
    input  i_key_vld, i_key, i_rkey_rdy, i_rd_idx,
    output o_key_rdy, o_rkey_vld, o_rkey, o_rkey_idx, o_busy, o_rd_key, o_store_done
  );
  modport master (
    output i_key_vld, i_key, i_rkey_rdy, i_rd_idx,
    input  o_key_rdy, o_rkey_vld, o_rkey, o_rkey_idx, o_busy, o_rd_key, o_store_done
  );
`else
  modport slave (
    input  i_key_vld, i_key, i_rkey_rdy,
    output o_key_rdy, o_rkey_vld, o_rkey, o_rkey_idx, o_busy
  );
  modport master (
    output i_key_vld, i_key, i_rkey_rdy,
    input  o_key_rdy, o_rkey_vld, o_rkey, o_rkey_idx, o_busy
  );
`endif

endinterface

// File: rtl/aes_key_expand_sbox.sv
// aes_sbox: four parallel AES S-boxes (SubWord), purely combinational.
// Each byte is the GF(2^8) inverse (as x^254) followed by the AES affine map.
module aes_sbox (
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    sub_word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sub_word[8*i +: 8] = sbox_byte(word[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion streaming 11 round keys, one word per cycle.
// Optional AES_KEY_EXP_STORE_EN keeps all round keys for random read-back.
module aes_key_expand
  import aes_pkg::*;
(
  input logic              i_clk,
  input logic              i_rst_n,
  aes_key_expand_if.slave  bus
);

  state_t     state;
  state_t     state_nxt;
  key_t       rkey;
  logic [3:0] idx;
  logic [1:0] sub;
  logic [95:0] work;
  word_t      sbox_in;
  word_t      sbox_hold;
  word_t      sbox_out;
  word_t      prev_word;
  word_t      link;
  word_t      new_word;
  key_t       next_rkey;
  logic       key_acc;
  logic       exp_done;

  assign key_acc  = (state == ST_IDLE) && bus.i_key_vld;
  assign exp_done = (state == ST_EXPAND) && (sub == 2'd3);

  assign bus.o_key_rdy  = (state == ST_IDLE);
  assign bus.o_busy     = (state != ST_IDLE);
  assign bus.o_rkey_vld = (state == ST_OUT);
  assign bus.o_rkey     = rkey;
  assign bus.o_rkey_idx = idx;

  // S-box input only changes in sub-cycle 0; it is parked otherwise.
  assign sbox_in = (state == ST_EXPAND && sub == 2'd0) ? rot_word(rkey[31:0]) : sbox_hold;

  aes_sbox u_sbox (
    .word     (sbox_in),
    .sub_word (sbox_out)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.i_key_vld) state_nxt = ST_OUT;
      ST_OUT:    if (bus.i_rkey_rdy) state_nxt = (idx == LAST_IDX) ? ST_IDLE : ST_EXPAND;
      ST_EXPAND: if (sub == 2'd3) state_nxt = ST_OUT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // New words build up in work; o_rkey keeps the previous round until all four exist.
  always_comb begin
    prev_word = '0;
    case (sub)
      2'd0: prev_word = rkey[127:96];
      2'd1: prev_word = rkey[95:64];
      2'd2: prev_word = rkey[63:32];
      2'd3: prev_word = rkey[31:0];
    endcase
    link      = (sub == 2'd0) ? (sbox_out ^ {RCON[idx + 4'd1], 24'h0}) : work[31:0];
    new_word  = prev_word ^ link;
    next_rkey = {work, new_word};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rkey      <= '0;
      idx       <= '0;
      sub       <= '0;
      work      <= '0;
      sbox_hold <= '0;
    end else begin
      sbox_hold <= sbox_in;
      if (key_acc) begin
        rkey <= bus.i_key;
        idx  <= '0;
        sub  <= '0;
      end
      if (state == ST_EXPAND) begin
        work <= {work[63:0], new_word};
        sub  <= sub + 2'd1;
        if (sub == 2'd3) begin
          rkey <= next_rkey;
          idx  <= idx + 4'd1;
        end
      end
    end
  end

`ifdef AES_KEY_EXP_STORE_EN
  key_t store [0:10];
  logic store_done;

  always_ff @(posedge i_clk) begin
    if (key_acc)  store[0] <= bus.i_key;
    if (exp_done) store[idx + 4'd1] <= next_rkey;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                                store_done <= 1'b0;
    else if (key_acc)                            store_done <= 1'b0;
    else if (exp_done && idx == LAST_IDX - 4'd1) store_done <= 1'b1;
  end

  assign bus.o_rd_key     = (bus.i_rd_idx <= LAST_IDX) ? store[bus.i_rd_idx] : '0;
  assign bus.o_store_done = store_done;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: table-driven key-schedule model plus directed FIPS-197 vectors.
module tb_aes_key_expand;

  typedef logic [127:0] sched_t [0:10];

  localparam logic [127:0] SBOX [0:15] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [7:0] RC [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_IDX1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_IDX10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_IDX10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests  = 0;
  int   failed = 0;
  bit   chk_en = 1'b0;

  aes_key_expand_if bus ();

  aes_key_expand dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX[b[7:4]];
    return row[8*(15 - b[3:0]) +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  task automatic expand_key(input logic [127:0] k, output sched_t rk);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {RC[i/4], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle-level model: key accept -> round 0 next cycle; each round handshake -> 4 dead cycles.
  sched_t m_rk;
  sched_t m_sched;
  bit     m_busy = 1'b0;
  bit     m_vld  = 1'b0;
  int     m_idx  = 0;
  int     m_wait = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_vld  <= 1'b0;
      m_idx  <= 0;
      m_wait <= 0;
    end else if (!m_busy) begin
      if (bus.i_key_vld) begin
        expand_key(bus.i_key, m_sched);
        m_rk   <= m_sched;
        m_busy <= 1'b1;
        m_vld  <= 1'b1;
        m_idx  <= 0;
      end
    end else if (m_vld) begin
      if (bus.i_rkey_rdy) begin
        m_vld <= 1'b0;
        if (m_idx == 10) m_busy <= 1'b0;
        else             m_wait <= 4;
      end
    end else if (m_wait == 1) begin
      m_vld  <= 1'b1;
      m_idx  <= m_idx + 1;
      m_wait <= 0;
    end else begin
      m_wait <= m_wait - 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rkey_vld", 128'(bus.o_rkey_vld), 128'(m_vld));
      check("busy", 128'(bus.o_busy), 128'(m_busy));
      check("key_rdy", 128'(bus.o_key_rdy), 128'(!m_busy));
      if (m_vld) begin
        check("rkey_idx", 128'(bus.o_rkey_idx), 128'(m_idx));
        check($sformatf("rkey[%0d]", m_idx), bus.o_rkey, m_rk[m_idx]);
      end
    end
  end

  task automatic send_key(input logic [127:0] k);
    bus.i_key     = k;
    bus.i_key_vld = 1'b1;
    @(negedge clk);
    bus.i_key_vld = 1'b0;
  endtask

  task automatic wait_idx(input int target, output int cnt);
    cnt = 0;
    while (!(bus.o_rkey_vld === 1'b1 && bus.o_rkey_idx == 4'(target)) && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check($sformatf("wait_idx%0d_timeout", target), 128'(cnt < 300), 128'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.o_busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 128'(n < 300), 128'd1);
  endtask

  initial begin
    sched_t      s;
    int          c1;
    int          c2;
    logic [127:0] held;

    bus.i_key_vld  = 1'b0;
    bus.i_key      = '0;
    bus.i_rkey_rdy = 1'b0;
`ifdef AES_KEY_EXP_STORE_EN
    bus.i_rd_idx   = '0;
`endif

    // Pin the model to published FIPS-197 values.
    expand_key(KEY_A, s);
    check("model_a_idx1", s[1], A_IDX1);
    check("model_a_idx10", s[10], A_IDX10);
    check("model_sbox", 128'(sub_word(32'hcf4f3c09)), 128'h8a84eb01);
    expand_key(KEY_B, s);
    check("model_b_idx10", s[10], B_IDX10);

    repeat (3) @(negedge clk);
    check("rst_vld", 128'(bus.o_rkey_vld), 128'd0);
    check("rst_rkey", bus.o_rkey, 128'd0);
    check("rst_idx", 128'(bus.o_rkey_idx), 128'd0);
    check("rst_busy", 128'(bus.o_busy), 128'd0);
    check("rst_key_rdy", 128'(bus.o_key_rdy), 128'd1);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Full schedule with a consumer that is always ready.
    bus.i_rkey_rdy = 1'b1;
    send_key(KEY_A);
    @(negedge clk);
    check("sbox_in_r1", 128'(dut.sbox_in), 128'hcf4f3c09);
    check("sbox_out_r1", 128'(dut.sbox_out), 128'h8a84eb01);
    wait_idx(1, c1);
    check("a_idx1", bus.o_rkey, A_IDX1);
    wait_idx(10, c2);
    check("a_idx10", bus.o_rkey, A_IDX10);
    check("latency_idx10", 128'(2 + c1 + c2), 128'd51);
    @(negedge clk);
    check("done_key_rdy", 128'(bus.o_key_rdy), 128'd1);
`ifdef AES_KEY_EXP_STORE_EN
    check("store_done", 128'(bus.o_store_done), 128'd1);
    bus.i_rd_idx = 4'd1;
    #1;
    check("rd_idx1", bus.o_rd_key, A_IDX1);
    bus.i_rd_idx = 4'd11;
    #1;
    check("rd_idx11", bus.o_rd_key, 128'd0);
    bus.i_rd_idx = 4'd0;
`endif

    // Backpressure at round 3.
    send_key(KEY_A);
    wait_idx(3, c1);
    bus.i_rkey_rdy = 1'b0;
    held = bus.o_rkey;
    repeat (7) begin
      @(negedge clk);
      check("bp_vld", 128'(bus.o_rkey_vld), 128'd1);
      check("bp_idx", 128'(bus.o_rkey_idx), 128'd3);
      check("bp_rkey", bus.o_rkey, held);
    end
    bus.i_rkey_rdy = 1'b1;
    wait_idx(10, c1);
    check("bp_idx10", bus.o_rkey, A_IDX10);
    @(negedge clk);
    wait_idle();

    // Second key offered during expansion is ignored.
    send_key(KEY_A);
    @(negedge clk);
    bus.i_key     = '0;
    bus.i_key_vld = 1'b1;
    check("busy_key_rdy", 128'(bus.o_key_rdy), 128'd0);
    @(negedge clk);
    bus.i_key_vld = 1'b0;
    wait_idx(10, c1);
    check("ignore_idx10", bus.o_rkey, A_IDX10);
    @(negedge clk);
    wait_idle();

    // Reset during sub-cycle 2 of round 4, then a fresh key.
    send_key(KEY_A);
    wait_idx(3, c1);
    repeat (3) @(negedge clk);
    check("sub_before_rst", 128'(dut.sub), 128'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_vld", 128'(bus.o_rkey_vld), 128'd0);
    check("mid_rst_busy", 128'(bus.o_busy), 128'd0);
    check("mid_rst_rkey", bus.o_rkey, 128'd0);
    check("mid_rst_idx", 128'(bus.o_rkey_idx), 128'd0);
    rst_n = 1'b1;
    send_key(KEY_B);
    wait_idx(10, c1);
    check("b_idx10", bus.o_rkey, B_IDX10);
    @(negedge clk);
    wait_idle();

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 Parameters: none; AES-128 only (Nk=4, Nr=10, 11 round keys).
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  synchronous, active-low reset.
REQ-004 i_key_vld  input  1  cipher key valid.
REQ-005 i_key  input  128  cipher key; word w0 = i_key[127:96].
REQ-006 o_key_rdy  output  1  key accepted when i_key_vld & o_key_rdy.
REQ-007 o_rkey_vld  output  1  round key valid.
REQ-008 o_rkey  output  128  round key; word 0 in [127:96].
REQ-009 o_rkey_idx  output  4  round index 0..10 of o_rkey.
REQ-010 i_rkey_rdy  input  1  consumer accepts when o_rkey_vld & i_rkey_rdy.
REQ-011 o_busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, OUT, EXPAND; o_key_rdy = 1 only in IDLE.
REQ-013 IDLE + key handshake at cycle T -> OUT; o_rkey = i_key, o_rkey_idx = 0, o_rkey_vld = 1 from T+1.
REQ-014 OUT: o_rkey, o_rkey_idx held stable while o_rkey_vld & !i_rkey_rdy.
REQ-015 OUT handshake with o_rkey_idx < 10 -> EXPAND; with o_rkey_idx = 10 -> IDLE, o_key_rdy = 1 next cycle.
REQ-016 EXPAND: exactly 4 cycles, one word per cycle (sub-cycle counter 0..3), then OUT with o_rkey_idx incremented; handshake at A gives o_rkey_vld = 1 at A+5.
REQ-017 Word 0 of round r: w[4r] = w[4r-4] ^ SubWord(RotWord(w[4r-1])) ^ {Rcon[r],24'h0}; words 1..3: w[i] = w[i-4] ^ w[i-1].
REQ-018 Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
REQ-019 SubWord uses the aes_sbox instance, combinational, same-cycle result; sbox input is RotWord(w[4r-1]) during sub-cycle 0 only, else held.
REQ-020 o_rkey_vld = 0 in IDLE and EXPAND; no partial round key is ever visible on o_rkey.
REQ-021 i_key_vld outside IDLE is ignored; no queuing.
REQ-022 i_rkey_rdy while o_rkey_vld = 0 has no effect.

Reset
REQ-023 i_rst_n = 0 at an edge -> IDLE, o_rkey_vld = 0, o_rkey = 0, o_rkey_idx = 0, o_busy = 0, o_key_rdy = 1 from next cycle, sub-cycle counter = 0.
REQ-024 Reset mid-EXPAND or mid-OUT aborts the schedule; the next accepted key restarts from round 0.

Configuration
REQ-025 Macro AES_KEY_EXP_STORE_EN: when defined, each round key is also written into an 11x128 array at its index on entry to OUT.
REQ-026 With AES_KEY_EXP_STORE_EN: extra ports i_rd_idx (input, 4) and o_rd_key (output, 128, combinational read; idx > 10 returns 0) plus o_store_done (output, 1), set on write of round 10 and cleared on next key accept or reset.
REQ-027 Without AES_KEY_EXP_STORE_EN: those ports and the array are absent; streaming behaviour is identical.

Structure
REQ-028 Shared package aes_pkg: 32-bit word and 128-bit key typedefs, FSM state enum, Rcon table constant, NUM_ROUNDS = 10.
REQ-029 Exactly one sub-module: the existing aes_sbox (32-bit in, 32-bit out), instantiated once.

Verification
REQ-030 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, i_rkey_rdy = 1 -> idx1 a0fafe1788542cb123a339392a6c7605, idx10 d014f9a8c9ee2589e13f0cc8b6630ca6; key-to-idx10 latency 1 + 10x5 = 51 cycles.
REQ-031 Same key, sub-cycle 0 of round 1: sbox input cf4f3c09, output 8a84eb01.
REQ-032 Backpressure: i_rkey_rdy = 0 for 7 cycles at idx 3 -> o_rkey/o_rkey_idx stable, o_rkey_vld held, sequence unchanged afterwards.
REQ-033 Second i_key_vld pulse with key 0 during EXPAND -> ignored, o_key_rdy = 0, all round keys match the first key.
REQ-034 Reset at sub-cycle 2 of round 4 -> o_rkey_vld = 0, o_busy = 0 next cycle; new key 000102030405060708090a0b0c0d0e0f then gives idx10 13111d7fe3944a17f307a78b4d2b30c5.
REQ-035 With AES_KEY_EXP_STORE_EN after REQ-030: o_store_done = 1; i_rd_idx = 1 -> a0fafe1788542cb123a339392a6c7605; i_rd_idx = 11 -> 0.
